// File: rtl/servo_pulse_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : servo_pulse_encoder                                        |
// | Description : Measures RC/servo PWM pulse widths in microseconds, maps   |
// |               them onto gesture codes 1..11 (1000..2000 us, 100 us       |
// |               bands), debounces codes across frames and falls back to    |
// |               gesture 0 ("hold") when the pulse train disappears.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module servo_pulse_encoder #(
  parameter int CLKS_PER_US   = 50,
  parameter int MIN_US        = 900,
  parameter int MAX_US        = 2100,
  parameter int TIMEOUT_US    = 25000,
  parameter int STABLE_FRAMES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [7:0]  gesture,
  output logic        gesture_valid,
  output logic [15:0] width_us,
  output logic        signal_lost
);

  localparam int PRESC_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLKS_PER_US - 1);
  localparam logic [15:0] MIN_W     = 16'(MIN_US);
  localparam logic [15:0] MAX_W     = 16'(MAX_US);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_US);
  localparam logic [3:0]  STABLE_N  = 4'(STABLE_FRAMES);

  typedef enum logic [1:0] {
    ST_ARM       = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEASURE   = 2'd2
  } state_t;

  state_t              state;
  logic                sync_meta;
  logic                sync_out;
  logic                sync_d;
  logic [1:0]          sync_primed;
  logic [PRESC_W-1:0]  presc;
  logic [15:0]         width_cnt;
  logic [15:0]         timeout_cnt;
  logic [7:0]          cand;
  logic [3:0]          match_cnt;

  logic                rise;
  logic                fall;
  logic                us_tick;
  logic                timeout_hit;
  logic [15:0]         width_next;
  logic [7:0]          code;
  logic [3:0]          match_next;

  assign rise        = sync_out & ~sync_d;
  assign fall        = ~sync_out & sync_d;
  assign us_tick     = (presc == PRESC_MAX);
  // Width including the microsecond that completes in this very cycle.
  assign width_next  = width_cnt + {15'd0, us_tick};
  // Fires once, on the cycle the counter would step onto TIMEOUT_US; a
  // rise detected in the same cycle restarts the count instead.
  assign timeout_hit = us_tick & ~rise & (timeout_cnt == (TIMEOUT_W - 16'd1));

  // Two-flop synchronizer plus delayed copy for edge detection; sync_primed
  // marks when sync_out holds a real sample rather than its reset value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta   <= 1'b0;
      sync_out    <= 1'b0;
      sync_d      <= 1'b0;
      sync_primed <= 2'b00;
    end else begin
      sync_meta   <= pwm_in;
      sync_out    <= sync_meta;
      sync_d      <= sync_out;
      sync_primed <= {sync_primed[0], 1'b1};
    end
  end

  // Microsecond prescaler and saturating since-last-rise counter, both
  // realigned on every rise so measured widths floor cleanly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc       <= '0;
      timeout_cnt <= 16'd0;
    end else if (rise) begin
      presc       <= '0;
      timeout_cnt <= 16'd0;
    end else begin
      presc <= us_tick ? '0 : presc + 1'b1;
      if (us_tick && (timeout_cnt != TIMEOUT_W)) begin
        timeout_cnt <= timeout_cnt + 16'd1;
      end
    end
  end

  // Width-to-code comparator chain: narrowest matching band wins.
  always_comb begin
    code = 8'd11;
    for (int k = 10; k >= 1; k--) begin
      if (width_next < 16'(950 + 100 * k)) begin
        code = 8'(k);
      end
    end
  end

  // Next match count for an accepted pulse, saturating at STABLE_FRAMES.
  always_comb begin
    match_next = 4'd1;
    if (code == cand) begin
      match_next = (match_cnt >= STABLE_N) ? STABLE_N : match_cnt + 4'd1;
    end
  end

  // Measurement FSM with debounce and loss handling; all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_ARM;
      width_cnt     <= 16'd0;
      cand          <= 8'd0;
      match_cnt     <= 4'd0;
      gesture       <= 8'd0;
      gesture_valid <= 1'b0;
      width_us      <= 16'd0;
      signal_lost   <= 1'b1;
    end else begin
      gesture_valid <= 1'b0;
      if (timeout_hit) begin
        signal_lost <= 1'b1;
        cand        <= 8'd0;
        match_cnt   <= 4'd0;
        state       <= ST_ARM;
        if (gesture != 8'd0) begin
          gesture       <= 8'd0;
          gesture_valid <= 1'b1;
        end
      end else begin
        case (state)
          ST_ARM: begin
            if (sync_primed[1] && !sync_out) begin
              state <= ST_WAIT_RISE;
            end
          end
          ST_WAIT_RISE: begin
            if (rise) begin
              width_cnt <= 16'd0;
              state     <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            if (fall) begin
              state <= ST_WAIT_RISE;
              if ((width_next < MIN_W) || (width_next > MAX_W)) begin
                match_cnt <= 4'd0;
              end else begin
                width_us    <= width_next;
                signal_lost <= 1'b0;
                cand        <= code;
                match_cnt   <= match_next;
                if ((match_next == STABLE_N) && (code != gesture)) begin
                  gesture       <= code;
                  gesture_valid <= 1'b1;
                end
              end
            end else if (width_next > MAX_W) begin
              match_cnt <= 4'd0;
              state     <= ST_ARM;
            end else begin
              width_cnt <= width_next;
            end
          end
          default: state <= ST_ARM;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
